gates_using_demux: RTL and testbench
====================================

// Module: gates_using_demux
// PURPOSE
//   Builds the seven basic logic functions of two 1-bit operands from 1:2 and 1:4 demultiplexers.
//   Constant 1 is routed by the operand bits to one-hot minterm lines, and each gate is an OR of minterms.
//   The block is a teaching/reference datapath primitive. Its results are registered so that it can sit
//   inside a clocked pipeline.
// PARAMETERS
//   REG_OUT  1  1 = outputs registered (1-cycle latency); 0 = outputs combinational, reset ignored
// PORTS
//   clk     in   1  single clock; all state updates on its rising edge
//   rst_n   in   1  asynchronous, active-low reset
//   a       in   1  operand A; also the NOT operand
//   b       in   1  operand B
//   not_y   out  1  ~a
//   and_y   out  1  a & b
//   or_y    out  1  a | b
//   nand_y  out  1  ~(a & b)
//   nor_y   out  1  ~(a | b)
//   xor_y   out  1  a ^ b
//   xnor_y  out  1  ~(a ^ b)
//   err     out  1  self-check mismatch flag (present only with GATES_DEMUX_SELFCHK_EN)
// BEHAVIOUR
//   - Demux 1:2: data=1'b1, sel=a -> y0 = (a==0), y1 = (a==1). not_y source = y0.
//   - Demux 1:4: data=1'b1, sel={a,b} -> m0..m3, exactly one high (one-hot).
//   - Minterm OR mapping:
//       and  = m3
//       or   = m1|m2|m3
//       nand = m0|m1|m2
//       nor  = m0
//       xor  = m1|m2
//       xnor = m0|m3
//   - Demuxes are separate submodules: demux_1to2 and demux_1to4, each with a data input.
//     Disabled outputs drive 0. No gate operator may be applied directly to a/b in the gate paths.
//   - REG_OUT=1:
//       a/b are sampled at the rising edge of clk; all seven outputs are updated from that sample.
//       Latency is 1 cycle; one new result every cycle; no handshake.
//   - Reset (rst_n=0, asynchronous): all outputs are cleared to 0 immediately, regardless of clk.
//     The outputs stay 0 while rst_n=0.
//   - Reset release: the first rising edge of clk with rst_n=1 loads the result for the current a/b.
//     Reset asserted mid-stream discards the pending result; there is no recovery of prior state.
//   - X/Z on a or b is not supported. Outputs for those inputs are undefined.
//   - REG_OUT=0: outputs follow a/b combinationally and clk/rst_n have no effect.
//     With GATES_DEMUX_SELFCHK_EN, err is also combinational in this mode.
// CONFIGURATION
//   GATES_DEMUX_SELFCHK_EN defined:
//     - Adds port err and a redundant direct-operator model (~a, a&b, ...).
//     - Every cycle, err is registered as the OR of mismatches between the demux result and the model.
//     - err resets to 0 and is 1 for one cycle per mismatching sample. It never fires on correct logic.
//   GATES_DEMUX_SELFCHK_EN undefined:
//     - No err port and no redundant logic.
//     - Gate outputs are identical in both builds.
// TESTING
//   1. rst_n=0 with a=1, b=1, no clk edge -> all outputs 0 immediately; they stay 0 until release.
//   2. Release reset, a=0, b=0, one clk edge -> not=1 and=0 or=0 nand=1 nor=1 xor=0 xnor=1.
//   3. a=0, b=1, clk edge -> not=1 and=0 or=1 nand=1 nor=0 xor=1 xnor=0.
//      a=1, b=0, clk edge -> not=0 and=0 or=1 nand=1 nor=0 xor=1 xnor=0.
//   4. a=1, b=1, clk edge -> not=0 and=1 or=1 nand=0 nor=0 xor=0 xnor=1.
//      Before the edge the outputs hold the previous values (1-cycle latency).
//   5. Change a/b every cycle through 00,01,10,11,00 -> each result appears exactly one edge later.
//      Then pulse rst_n low mid-sequence -> outputs 0 asynchronously, and the next edge after release
//      gives the current result.
//   6. Build with GATES_DEMUX_SELFCHK_EN and run scenarios 2-5 -> err stays 0 throughout.
//      Build with REG_OUT=0 -> outputs settle within the same timestep as the a/b change.

Source files
------------

// File: rtl/gates_using_demux.sv
// Seven two-input logic functions built from 1:2 and 1:4 demultiplexers, optionally registered.
// Optional redundant self-check (err port) is enabled by defining GATES_DEMUX_SELFCHK_EN.
`timescale 1ns/1ps

module demux_1to2 (
  input  logic i_data,
  input  logic i_sel,
  output logic o_y0,
  output logic o_y1
);

  // Route the data bit to the selected output; the unselected output is held at 0.
  always_comb begin
    o_y0 = 1'b0;
    o_y1 = 1'b0;
    if (i_sel == 1'b0) begin
      o_y0 = i_data;
    end else begin
      o_y1 = i_data;
    end
  end

endmodule

module demux_1to4 (
  input  logic       i_data,
  input  logic [1:0] i_sel,
  output logic [3:0] o_y
);

  // Route the data bit to exactly one of four lines.
  always_comb begin
    o_y = 4'b0000;
    case (i_sel)
      2'b00:   o_y[0] = i_data;
      2'b01:   o_y[1] = i_data;
      2'b10:   o_y[2] = i_data;
      2'b11:   o_y[3] = i_data;
      default: o_y = 4'b0000;
    endcase
  end

endmodule

module gates_using_demux #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic not_y,
  output logic and_y,
  output logic or_y,
  output logic nand_y,
  output logic nor_y,
  output logic xor_y,
  output logic xnor_y
`ifdef GATES_DEMUX_SELFCHK_EN
  , output logic err
`endif
);

  logic       w_d2_y0;
  logic       w_d2_y1;
  logic [3:0] w_m;
  logic [6:0] w_gates;   // {not, and, or, nand, nor, xor, xnor}
  logic [6:0] w_out;

  demux_1to2 u_demux_1to2 (
    .i_data (1'b1),
    .i_sel  (a),
    .o_y0   (w_d2_y0),
    .o_y1   (w_d2_y1)
  );

  demux_1to4 u_demux_1to4 (
    .i_data (1'b1),
    .i_sel  ({a, b}),
    .o_y    (w_m)
  );

  // Each gate is the OR of the minterm lines where its truth table is 1.
  assign w_gates = {
    w_d2_y0,
    w_m[3],
    w_m[1] | w_m[2] | w_m[3],
    w_m[0] | w_m[1] | w_m[2],
    w_m[0],
    w_m[1] | w_m[2],
    w_m[0] | w_m[3]
  };

  generate
    if (REG_OUT) begin : g_reg
      logic [6:0] r_gates;

      // Capture the gate results each cycle; reset clears them immediately.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_gates <= 7'b0000000;
        end else begin
          r_gates <= w_gates;
        end
      end

      assign w_out = r_gates;
    end else begin : g_comb
      assign w_out = w_gates;
    end
  endgenerate

  assign {not_y, and_y, or_y, nand_y, nor_y, xor_y, xnor_y} = w_out;

`ifdef GATES_DEMUX_SELFCHK_EN
  logic [6:0] w_model;
  logic       w_mis;

  // Independent operator-based reference; any disagreement with the demux path flags err.
  assign w_model = {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  assign w_mis   = |(w_gates ^ w_model);

  generate
    if (REG_OUT) begin : g_err_reg
      logic r_err;

      // Register the mismatch alongside the sampled results.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_err <= 1'b0;
        end else begin
          r_err <= w_mis;
        end
      end

      assign err = r_err;
    end else begin : g_err_comb
      assign err = w_mis;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_gates_using_demux.sv
// Directed bench for gates_using_demux (default REG_OUT=1); outputs packed as
// {not, and, or, nand, nor, xor, xnor} and compared with hand-computed vectors.
`timescale 1ns/1ps

module tb_gates_using_demux;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic not_y, and_y, or_y, nand_y, nor_y, xor_y, xnor_y;
`ifdef GATES_DEMUX_SELFCHK_EN
  logic err;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  localparam logic [6:0] EXP_00   = 7'b1001101;
  localparam logic [6:0] EXP_01   = 7'b1011010;
  localparam logic [6:0] EXP_10   = 7'b0011010;
  localparam logic [6:0] EXP_11   = 7'b0110001;
  localparam logic [6:0] EXP_ZERO = 7'b0000000;

  gates_using_demux #(.REG_OUT(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .not_y  (not_y),
    .and_y  (and_y),
    .or_y   (or_y),
    .nand_y (nand_y),
    .nor_y  (nor_y),
    .xor_y  (xor_y),
    .xnor_y (xnor_y)
`ifdef GATES_DEMUX_SELFCHK_EN
    , .err  (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {not_y, and_y, or_y, nand_y, nor_y, xor_y, xnor_y};
  endfunction

  task automatic check_err(input string tag);
`ifdef GATES_DEMUX_SELFCHK_EN
    check_val(tag, {6'b000000, err}, 7'b0000000);
`endif
  endtask

  // Change operands at the falling edge, confirm old result holds, then confirm new result after the edge.
  task automatic step(input logic va, input logic vb, input logic [6:0] prev,
                      input logic [6:0] nxt, input string tag);
    @(negedge clk);
    a = va;
    b = vb;
    #1;
    check_val({tag, "_hold"}, outs(), prev);
    @(posedge clk);
    #1;
    check_val({tag, "_new"}, outs(), nxt);
    check_err({tag, "_err"});
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    a     = 1'b1;
    b     = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async", outs(), EXP_ZERO);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold", outs(), EXP_ZERO);

    @(negedge clk);
    rst_n = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    #1;
    check_val("rel_before_edge", outs(), EXP_ZERO);
    @(posedge clk);
    #1;
    check_val("rel_00", outs(), EXP_00);
    check_err("rel_err");

    step(1'b0, 1'b1, EXP_00, EXP_01, "v01");
    step(1'b1, 1'b0, EXP_01, EXP_10, "v10");
    step(1'b1, 1'b1, EXP_10, EXP_11, "v11");
    step(1'b0, 1'b0, EXP_11, EXP_00, "v00");
    step(1'b0, 1'b1, EXP_00, EXP_01, "s01");
    step(1'b1, 1'b1, EXP_01, EXP_11, "s11");

    // Mid-stream reset pulse between edges discards the pending result.
    @(negedge clk);
    a = 1'b1;
    b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_async", outs(), EXP_ZERO);
    #1 rst_n = 1'b1;
    #0.5;
    check_val("mid_rst_released", outs(), EXP_ZERO);
    @(posedge clk);
    #1;
    check_val("mid_rst_first", outs(), EXP_10);
    check_err("mid_rst_err");

    step(1'b0, 1'b0, EXP_10, EXP_00, "post00");
    step(1'b1, 1'b1, EXP_00, EXP_11, "post11");

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
